// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the multiply-accumulate stage.
package mult_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps to all ones when the sum carries out of ACC_WIDTH bits.
module sat_adder #(
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);

  logic [ACC_WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b};
  assign sat    = w_full[ACC_WIDTH];
  assign sum    = sat ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];

endmodule

// File: rtl/mult_accum_stage.sv
// Handshaked accumulator that sums a programmed number of multiplier products
// into one saturated dot-product result with a sticky overflow flag.
module mult_accum_stage #(
  parameter int DATA_WIDTH = mult_pkg::DATA_WIDTH,
  parameter int PROD_WIDTH = 2 * DATA_WIDTH,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_LEN    = 16,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [PROD_WIDTH-1:0] prod,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  import mult_pkg::state_t;
  import mult_pkg::ST_IDLE;
  import mult_pkg::ST_ACCUM;
  import mult_pkg::ST_DONE;

  localparam logic [LEN_WIDTH-1:0] LP_MAX_LEN = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LP_ONE     = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LP_ZERO    = LEN_WIDTH'(0);

  state_t               r_state;
  state_t               w_state_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 r_overflow;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_sat;
  logic                 w_xfer;
  logic [LEN_WIDTH-1:0] w_len_clamped;

  assign w_prod_ext    = ACC_WIDTH'(prod);
  assign w_len_clamped = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
  assign w_xfer        = in_valid && (r_state == ST_ACCUM);

  sat_adder #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_adder (
    .a  (r_acc),
    .b  (w_prod_ext),
    .sum(w_sum),
    .sat(w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE, never during DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_clamped == LP_ZERO) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_ACCUM;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_xfer && (r_count == LP_ONE)) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_count     <= LP_ZERO;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_count    <= w_len_clamped;
            r_overflow <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc      <= w_sum;
            r_count    <= r_count - LP_ONE;
            r_overflow <= r_overflow | w_sat;
          end
        end
        default: begin
        end
      endcase
      // Flags track the state being entered so they line up with r_state.
      r_out_valid <= (w_state_next == ST_DONE);
      r_busy      <= (w_state_next != ST_IDLE);
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign result    = r_acc;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mult_accum_stage.sv
// Directed scoreboard bench for mult_accum_stage with a 10-bit accumulator.
module tb_mult_accum_stage;

  localparam int PW      = mult_pkg::PROD_WIDTH;
  localparam int AW      = 10;
  localparam int ML      = 16;
  localparam int LW      = $clog2(ML + 1);
  localparam int ACC_MAX = (1 << AW) - 1;

  typedef struct {
    int res;
    int ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic [PW-1:0] prod;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] result;
  logic          overflow;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_acc;
  int   m_ovf;
  int   m_left;

  always #5 clk = ~clk;

  mult_accum_stage #(
    .ACC_WIDTH(AW),
    .MAX_LEN  (ML)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .prod     (prod),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int l);
    int cl;
    cl    = (l > ML) ? ML : l;
    start = 1'b1;
    len   = LW'(l);
    step();
    start  = 1'b0;
    m_acc  = 0;
    m_ovf  = 0;
    m_left = cl;
    if (cl == 0) sb.push_back('{0, 0});
  endtask

  task automatic feed(input int p);
    prod     = PW'(p);
    in_valid = 1'b1;
    for (int w = 0; w < 20 && in_ready !== 1'b1; w++) step();
    check("in_ready_wait", in_ready, 1);
    step();
    m_acc = m_acc + p;
    if (m_acc > ACC_MAX) begin
      m_acc = ACC_MAX;
      m_ovf = 1;
    end
    m_left--;
    if (m_left == 0) sb.push_back('{m_acc, m_ovf});
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   w;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check({tag, "_valid"}, out_valid, 1);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    check({tag, "_result"}, result, e.res);
    check({tag, "_overflow"}, overflow, e.ovf);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    logic seen;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    prod      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();

    // Basic dot product with in_valid held high.
    start_op(3);
    feed(15);
    feed(30);
    feed(225);
    in_valid = 1'b0;
    check("t1_latency", out_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_result_const", result, 270);
    drain("t1");

    // Stalled input: the count must hold across idle cycles.
    start_op(2);
    feed(100);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_ready", in_ready, 1);
      check("t2_stall_valid", out_valid, 0);
    end
    feed(50);
    in_valid = 1'b0;
    check("t2_latency", out_valid, 1);
    drain("t2");

    // Saturation, then the flag clears on the next operation.
    start_op(5);
    for (int i = 0; i < 5; i++) feed(225);
    in_valid = 1'b0;
    check("t3_sat_const", result, ACC_MAX);
    drain("t3");
    start_op(1);
    feed(7);
    in_valid = 1'b0;
    drain("t3b");

    // Output backpressure with a start pulse that must be ignored.
    start_op(1);
    feed(20);
    in_valid = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_result", result, e.res);
      check("t4_hold_ready", in_ready, 0);
      start = (i == 1);
      len   = LW'(3);
      step();
      start = 1'b0;
    end
    check("t4_hold_overflow", overflow, e.ovf);
    out_ready = 1'b1;
    start     = 1'b1;
    len       = LW'(2);
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t4_valid_drop", out_valid, 0);
    check("t4_idle", busy, 0);
    step();
    check("t4_start_ignored", busy, 0);

    // Zero length completes one cycle after start.
    start_op(0);
    check("t5_len0_latency", out_valid, 1);
    drain("t5a");

    // Over-long length is clamped to MAX_LEN transfers.
    start_op(31);
    for (int i = 0; i < ML; i++) feed(1);
    in_valid = 1'b0;
    check("t5_clamp_valid", out_valid, 1);
    check("t5_clamp_ready", in_ready, 0);
    drain("t5b");

    // Reset mid-operation aborts without emitting a result.
    start_op(4);
    feed(5);
    feed(6);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_result", result, 0);
    check("t6_rst_overflow", overflow, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("t6_no_result", seen, 0);
    start_op(1);
    feed(9);
    in_valid = 1'b0;
    drain("t6");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
